// File: rtl/vending_txn_core.sv
// Vending transaction engine: coin accumulation, pricing, vend on confirm,
// and greedy coin-by-coin change/refund over a valid/ack dispenser handshake.
module vending_txn_core #(
    parameter int                     NUM_COINS      = 5,
    parameter logic [8*NUM_COINS-1:0] COIN_VALUES    = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1},
    parameter int                     MONEY_W        = 8,
    parameter int                     PRICE_W        = 7,
    parameter logic [31:0]            TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_COINS-1:0] coin_pulse,
    input  logic                 sel_goods,
    input  logic [PRICE_W-1:0]   unit_price,
    input  logic [1:0]           qty,
    input  logic                 confirm,
    input  logic                 cancel,
    input  logic                 coin_out_ack,
    output logic [2:0]           state_out,
    output logic [MONEY_W-1:0]   need_money,
    output logic [MONEY_W-1:0]   input_money,
    output logic [MONEY_W-1:0]   change_money,
    output logic                 vend_pulse,
    output logic [NUM_COINS-1:0] coin_out,
    output logic                 coin_out_valid,
    output logic                 error
);

    localparam int IDX_W = $clog2(NUM_COINS);
    localparam int SUM_W = ((MONEY_W > 8) ? MONEY_W : 8) + 4;
    localparam int CW    = ((PRICE_W + 2) > MONEY_W) ? (PRICE_W + 2) : MONEY_W;
    localparam logic [SUM_W-1:0] MONEY_MAX_S = SUM_W'((64'd1 << MONEY_W) - 64'd1);
    localparam logic [CW-1:0]    MONEY_MAX_C = CW'((64'd1 << MONEY_W) - 64'd1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PAY         = 3'd1,
        VEND        = 3'd2,
        CHANGE      = 3'd3,
        CHANGE_WAIT = 3'd4
    } state_t;

    state_t               state, state_next;
    logic [MONEY_W-1:0]   need_next, input_next, change_next;
    logic [31:0]          timer, timer_next;
    logic [IDX_W-1:0]     coin_idx, idx_next;
    logic                 error_next;
    logic [SUM_W-1:0]     total_wide;
    logic [MONEY_W-1:0]   total_next;
    logic                 coins_ok, coin_taken;
    logic [CW-1:0]        price_wide;

    function automatic logic [SUM_W-1:0] pulse_sum(input logic [NUM_COINS-1:0] p);
        pulse_sum = '0;
        for (int i = 0; i < NUM_COINS; i++)
            if (p[i]) pulse_sum = pulse_sum + SUM_W'(COIN_VALUES[8*i +: 8]);
    endfunction

    function automatic logic [MONEY_W-1:0] coin_value(input logic [IDX_W-1:0] idx);
        coin_value = MONEY_W'(COIN_VALUES[8*idx +: 8]);
    endfunction

    // Denominations ascend with index, so the last fitting index is the largest coin.
    function automatic logic [IDX_W-1:0] select_coin(input logic [MONEY_W-1:0] amt);
        select_coin = '0;
        for (int i = 0; i < NUM_COINS; i++)
            if (SUM_W'(COIN_VALUES[8*i +: 8]) <= SUM_W'(amt)) select_coin = IDX_W'(i);
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            need_money   <= '0;
            input_money  <= '0;
            change_money <= '0;
            timer        <= '0;
            coin_idx     <= '0;
            error        <= 1'b0;
        end else begin
            state        <= state_next;
            need_money   <= need_next;
            input_money  <= input_next;
            change_money <= change_next;
            timer        <= timer_next;
            coin_idx     <= idx_next;
            error        <= error_next;
        end
    end

    always_comb begin
        state_next  = state;
        need_next   = need_money;
        input_next  = input_money;
        change_next = change_money;
        timer_next  = timer;
        idx_next    = coin_idx;
        error_next  = 1'b0;
        total_wide  = SUM_W'(input_money) + pulse_sum(coin_pulse);
        coins_ok    = (total_wide <= MONEY_MAX_S);
        coin_taken  = coins_ok && (coin_pulse != '0);
        total_next  = coins_ok ? total_wide[MONEY_W-1:0] : input_money;
        price_wide  = CW'(unit_price) * CW'(qty);
        case (state)
            IDLE: begin
                if (sel_goods) begin
                    if (qty == 2'd0 || price_wide > MONEY_MAX_C) begin
                        error_next = 1'b1;
                    end else begin
                        need_next   = price_wide[MONEY_W-1:0];
                        input_next  = '0;
                        change_next = '0;
                        timer_next  = '0;
                        state_next  = PAY;
                    end
                end
            end
            PAY: begin
                error_next = !coins_ok;
                input_next = total_next;
                timer_next = coin_taken ? 32'd0 : timer + 32'd1;
                if (cancel) begin
                    change_next = total_next;
                    state_next  = CHANGE;
                end else if (confirm && total_next >= need_money) begin
                    change_next = total_next - need_money;
                    state_next  = VEND;
                end else if (!coin_taken && (timer + 32'd1) >= TIMEOUT_CYCLES) begin
                    change_next = total_next;
                    state_next  = CHANGE;
                end
            end
            VEND: state_next = CHANGE;
            CHANGE: begin
                if (change_money == '0) begin
                    need_next  = '0;
                    input_next = '0;
                    state_next = IDLE;
                end else begin
                    idx_next   = select_coin(change_money);
                    state_next = CHANGE_WAIT;
                end
            end
            CHANGE_WAIT: begin
                if (coin_out_ack) begin
                    change_next = change_money - coin_value(coin_idx);
                    state_next  = CHANGE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        state_out      = state;
        vend_pulse     = (state == VEND);
        coin_out_valid = (state == CHANGE_WAIT);
        coin_out       = '0;
        if (state == CHANGE_WAIT) coin_out = NUM_COINS'(1) << coin_idx;
    end

endmodule

// File: tb/tb_vending_txn_core.sv
// Scoreboard bench for vending_txn_core: expected dispensed coins are queued at
// stimulus time and popped as the dispenser handshake completes.
module tb_vending_txn_core;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [4:0] coin_pulse = '0;
    logic       sel_goods = 1'b0;
    logic [6:0] unit_price = '0;
    logic [1:0] qty = '0;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic       coin_out_ack = 1'b0;
    logic [2:0] state_out;
    logic [7:0] need_money, input_money, change_money;
    logic       vend_pulse, coin_out_valid, error;
    logic [4:0] coin_out;

    int checks = 0;
    int errors = 0;
    int exp_change = 0;
    logic [4:0] exp_coins[$];

    vending_txn_core #(.TIMEOUT_CYCLES(32'd10)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .coin_pulse(coin_pulse),
        .sel_goods(sel_goods), .unit_price(unit_price), .qty(qty),
        .confirm(confirm), .cancel(cancel), .coin_out_ack(coin_out_ack),
        .state_out(state_out), .need_money(need_money), .input_money(input_money),
        .change_money(change_money), .vend_pulse(vend_pulse), .coin_out(coin_out),
        .coin_out_valid(coin_out_valid), .error(error)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int coin_val(input logic [4:0] c);
        case (c)
            5'h01: coin_val = 1;
            5'h02: coin_val = 5;
            5'h04: coin_val = 10;
            5'h08: coin_val = 20;
            5'h10: coin_val = 50;
            default: coin_val = 0;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_coin(input logic [4:0] c);
        coin_pulse = c;
        cyc(1);
        coin_pulse = '0;
    endtask

    task automatic select(input logic [6:0] p, input logic [1:0] q);
        unit_price = p;
        qty = q;
        sel_goods = 1'b1;
        cyc(1);
        sel_goods = 1'b0;
    endtask

    // Odd-numbered coins hold the ack off for dly cycles.
    task automatic drain(input int dly);
        int n;
        int guard;
        logic [4:0] exp_c;
        n = 0;
        while (exp_coins.size() != 0) begin
            guard = 0;
            while (coin_out_valid !== 1'b1 && guard < 8) begin
                cyc(1);
                guard++;
            end
            exp_c = exp_coins.pop_front();
            if (coin_out_valid !== 1'b1) begin
                check_val("coin_valid_wait", 32'(coin_out_valid), 32'd1);
                exp_coins.delete();
                return;
            end
            check_val("coin_out", 32'(coin_out), 32'(exp_c));
            if (n % 2 == 1) begin
                for (int d = 0; d < dly; d++) begin
                    cyc(1);
                    check_val("coin_hold", 32'({coin_out_valid, coin_out}), 32'({1'b1, exp_c}));
                end
            end
            exp_change = exp_change - coin_val(exp_c);
            coin_out_ack = 1'b1;
            cyc(1);
            coin_out_ack = 1'b0;
            check_val("valid_drop", 32'(coin_out_valid), 32'd0);
            check_val("change_left", 32'(change_money), 32'(exp_change));
            n++;
        end
    endtask

    task automatic count_pay(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (state_out == 3'd1 && n < 40) begin
            cyc(1);
            n++;
        end
        check_val(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        cyc(2);
        #2 sys_rst = 1'b0;
        cyc(1);
        check_val("rst_state", 32'(state_out), 32'd0);
        check_val("rst_money", 32'({need_money, input_money, change_money}), 32'd0);
        check_val("rst_flags", 32'({vend_pulse, coin_out_valid, error, coin_out}), 32'd0);

        coin_out_ack = 1'b1;
        pulse_coin(5'h10);
        coin_out_ack = 1'b0;
        check_val("idle_ignore", 32'({state_out, input_money, error}), 32'd0);

        // Exact payment, no change
        select(7'd15, 2'd2);
        check_val("sel_state", 32'(state_out), 32'd1);
        check_val("sel_need", 32'(need_money), 32'd30);
        pulse_coin(5'h08);
        pulse_coin(5'h04);
        check_val("exact_input", 32'(input_money), 32'd30);
        confirm = 1'b1;
        cyc(1);
        confirm = 1'b0;
        check_val("exact_vend", 32'({state_out, vend_pulse}), 32'({3'd2, 1'b1}));
        check_val("exact_change", 32'(change_money), 32'd0);
        cyc(1);
        check_val("exact_vend_off", 32'({state_out, vend_pulse, coin_out_valid}), 32'({3'd3, 2'b00}));
        cyc(1);
        check_val("exact_idle", 32'({state_out, coin_out_valid}), 32'd0);
        check_val("exact_clear", 32'({need_money, input_money}), 32'd0);

        // Change 43 with delayed acks
        select(7'd7, 2'd1);
        pulse_coin(5'h10);
        confirm = 1'b1;
        exp_coins.push_back(5'h08); exp_coins.push_back(5'h08);
        exp_coins.push_back(5'h01); exp_coins.push_back(5'h01); exp_coins.push_back(5'h01);
        exp_change = 43;
        cyc(1);
        confirm = 1'b0;
        check_val("c43_vend", 32'(vend_pulse), 32'd1);
        check_val("c43_change", 32'(change_money), 32'd43);
        drain(5);
        cyc(1);
        check_val("c43_idle", 32'({state_out, need_money, input_money}), 32'd0);

        // Insufficient confirm, then cancel with a coin in the same cycle
        select(7'd15, 2'd2);
        pulse_coin(5'h04);
        confirm = 1'b1;
        cyc(1);
        confirm = 1'b0;
        check_val("short_confirm", 32'({state_out, vend_pulse}), 32'({3'd1, 1'b0}));
        cancel = 1'b1;
        coin_pulse = 5'h02;
        exp_coins.push_back(5'h04); exp_coins.push_back(5'h02);
        exp_change = 15;
        cyc(1);
        cancel = 1'b0;
        coin_pulse = '0;
        check_val("cancel_state", 32'(state_out), 32'd3);
        check_val("cancel_change", 32'(change_money), 32'd15);
        drain(2);
        cyc(1);
        check_val("cancel_idle", 32'(state_out), 32'd0);

        // Overflow rejection at 250
        select(7'd1, 2'd1);
        repeat (5) pulse_coin(5'h10);
        check_val("ovf_input", 32'(input_money), 32'd250);
        check_val("ovf_noerr", 32'(error), 32'd0);
        pulse_coin(5'h10);
        check_val("ovf50_err", 32'(error), 32'd1);
        check_val("ovf50_input", 32'(input_money), 32'd250);
        cyc(1);
        check_val("ovf_err_pulse", 32'(error), 32'd0);
        pulse_coin(5'h03);
        check_val("ovf6_err", 32'(error), 32'd1);
        check_val("ovf6_input", 32'(input_money), 32'd250);
        cancel = 1'b1;
        repeat (5) exp_coins.push_back(5'h10);
        exp_change = 250;
        cyc(1);
        cancel = 1'b0;
        drain(0);
        cyc(1);
        check_val("ovf_idle", 32'(state_out), 32'd0);

        // Payment timeout and restart by a late coin
        select(7'd10, 2'd1);
        pulse_coin(5'h02);
        exp_change = 5;
        count_pay("timeout_cycles", 10);
        check_val("timeout_change", 32'(change_money), 32'd5);
        exp_coins.push_back(5'h02);
        drain(0);
        cyc(1);
        select(7'd10, 2'd1);
        pulse_coin(5'h02);
        cyc(8);
        pulse_coin(5'h02);
        check_val("restart_state", 32'(state_out), 32'd1);
        check_val("restart_input", 32'(input_money), 32'd10);
        exp_change = 10;
        count_pay("restart_cycles", 10);
        exp_coins.push_back(5'h04);
        drain(0);
        cyc(1);

        // Reset in the middle of a dispense
        select(7'd7, 2'd1);
        pulse_coin(5'h10);
        confirm = 1'b1;
        cyc(1);
        confirm = 1'b0;
        cyc(2);
        check_val("mid_valid", 32'({state_out, coin_out_valid}), 32'({3'd4, 1'b1}));
        #2 sys_rst = 1'b1;
        #1;
        check_val("arst_valid", 32'({coin_out_valid, coin_out}), 32'd0);
        check_val("arst_state", 32'(state_out), 32'd0);
        check_val("arst_money", 32'({need_money, input_money, change_money}), 32'd0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        cyc(1);

        // Selection boundaries
        select(7'd20, 2'd0);
        check_val("qty0_err", 32'({state_out, error}), 32'({3'd0, 1'b1}));
        select(7'd127, 2'd3);
        check_val("price_ovf_err", 32'({state_out, error}), 32'({3'd0, 1'b1}));
        select(7'd85, 2'd3);
        check_val("price_max", 32'({state_out, error, need_money}), 32'({3'd1, 1'b0, 8'd255}));
        cancel = 1'b1;
        cyc(1);
        cancel = 1'b0;
        check_val("zero_refund", 32'({state_out, change_money}), 32'({3'd3, 8'd0}));
        cyc(1);
        check_val("zero_refund_idle", 32'({state_out, coin_out_valid}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_txn_core.md
# vending_txn_core

Parametrised vending transaction engine: accumulates debounced coin pulses from any number of coin channels with configurable denominations, computes the price for a selected good and quantity, and vends on confirm. It returns change or a full refund as a greedy sequence of physical coins over a valid/ack handshake. It sits between the per-key debounce filters and the display/LED drivers, and replaces the fixed 5-coin transition logic with a width- and channel-generic core that adds payment timeout and coin-level change dispensing.

## Interface
- NUM_COINS, 5, number of coin channels (2..8)
- COIN_VALUES, {8'd50,8'd20,8'd10,8'd5,8'd1}, packed 8-bit denominations; index 0 is the LSB byte; values strictly ascending with index; COIN_VALUES[0] must be 1
- MONEY_W, 8, width of all money quantities
- PRICE_W, 7, width of unit price
- TIMEOUT_CYCLES, 32'd500_000_000, idle cycles in PAY before auto-refund

- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- coin_pulse  in  NUM_COINS  one-cycle debounced coin-insert pulses, bit i = COIN_VALUES[i]
- sel_goods  in  1  pulse: latch unit_price and qty, start a transaction
- unit_price  in  PRICE_W  price of the selected good
- qty  in  2  quantity, 1..3
- confirm  in  1  pulse: attempt purchase
- cancel  in  1  pulse: abort and refund
- coin_out_ack  in  1  dispenser has taken the presented coin
- state_out  out  3  current state encoding
- need_money  out  MONEY_W  price × qty of current transaction
- input_money  out  MONEY_W  accumulated inserted money
- change_money  out  MONEY_W  change still owed
- vend_pulse  out  1  one-cycle pulse: release goods
- coin_out  out  NUM_COINS  one-hot coin to dispense, valid with coin_out_valid
- coin_out_valid  out  1  coin_out presented
- error  out  1  one-cycle pulse on rejected selection or rejected coins

## Operation
- States: IDLE=0, PAY=1, VEND=2, CHANGE=3, CHANGE_WAIT=4. Reset: state IDLE, all outputs 0, timeout counter 0.
- IDLE: sel_goods with qty≠0 and unit_price×qty ≤ 2^MONEY_W−1 → latch need_money, clear input_money, PAY. qty=0 or overflow → error pulse, stay IDLE. Coins, confirm and cancel in IDLE are ignored (no error).
- PAY: per cycle, sum = Σ COIN_VALUES[i] over set coin_pulse bits. If input_money+sum overflows MONEY_W, all coins that cycle are rejected (error pulse, total unchanged); otherwise total_next = input_money+sum. Coins arriving in the same cycle as confirm/cancel are included in total_next.
- PAY priority: cancel > confirm > timeout. cancel → change_money=total_next, CHANGE. confirm with total_next ≥ need_money → VEND, change_money=total_next−need_money. confirm with insufficient funds is ignored. sel_goods in PAY is ignored.
- Timeout counter clears on entry to PAY and on any accepted coin; reaching TIMEOUT_CYCLES → refund exactly as cancel.
- VEND: vend_pulse=1 for exactly this one cycle, then CHANGE.
- CHANGE: change_money=0 → clear input_money and need_money, IDLE. Otherwise select the highest index i with COIN_VALUES[i] ≤ change_money, drive coin_out=one-hot(i), coin_out_valid=1, CHANGE_WAIT.
- CHANGE_WAIT: coin_out and coin_out_valid held stable until coin_out_ack; on ack, change_money −= COIN_VALUES[i], drop valid, CHANGE. Coins, confirm, cancel and sel_goods are ignored in VEND/CHANGE/CHANGE_WAIT.
- sys_rst at any time, including mid-dispense: immediate return to IDLE, valid dropped, owed change discarded.

## Timing
- All outputs registered; state_out reflects a transition one cycle after the causing input.
- input_money updates the cycle after an accepted coin pulse.
- confirm at cycle t → vend_pulse at t+1 → CHANGE at t+2 → coin_out_valid at t+3 when change is owed.
- Per dispensed coin: minimum 2 cycles (valid, ack in the same cycle, then reselection); ack may be held off indefinitely.
- coin_out_ack while coin_out_valid=0 is ignored.

## Test plan
- Select price 15, qty 2 → need_money=30; insert 20,10 → input 30; confirm → vend_pulse one cycle, change 0, IDLE in 2 cycles with no coin_out.
- need 7; insert 50 → confirm → change 43 dispensed as 20,20,1,1,1 (coin_out 0x08,0x08,0x01,0x01,0x01), acks delayed 0 and 5 cycles.
- need 30; insert 10; confirm → ignored; cancel in the same cycle as a 5 pulse → refund 15 as 10,5.
- Input 250, then a 50 pulse → error, input stays 250; 5 and 1 pulses in the same cycle → input 256-wrap rejected too (error), total 250.
- Small TIMEOUT_CYCLES=10: insert 5, then no activity → refund 5 after 10 cycles; a coin at cycle 9 restarts the count.
- Assert sys_rst during CHANGE_WAIT → coin_out_valid=0 immediately, state IDLE, all money outputs 0; qty=0 selection → error pulse, remains IDLE.
